zero2asic_host: RTL and testbench

// - Serial initiator for the zero2asic cs/data_in/data_out peripheral.
// - Takes a parallel word over a valid/ready handshake, asserts cs and shifts the word MSB-first onto sdo.
// - Captures the peripheral's sdi return stream into rx_data and pulses rx_valid.
// - Sits between an on-chip controller (or test harness) and the peripheral pins.

---
 rtl/zero2asic_host.sv | 185 ++++++++++++++++++
 tb/tb_zero2asic_host.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/zero2asic_host.sv
// zero2asic_host: serial initiator for the zero2asic cs/data_in/data_out peripheral.
// Accepts a parallel word over valid/ready, raises cs_out and shifts the word
// MSB-first onto sdo, captures the echoed sdi stream and pulses rx_valid.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   tx_data/valid     word to send and its valid; tx_ready high only in IDLE
//   rx_data/valid     captured word (held) and one-cycle update pulse
//   busy              transfer in progress (SHIFT or FLUSH)
//   cs_out, sdo, sdi  peripheral pins
module zero2asic_host #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned BIT_CYCLES = 1,
   parameter int unsigned LATENCY    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             cs_out,
   output logic             sdo,
   input  logic             sdi
);

   localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLUSH} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   tx_sr_q, tx_sr_d;
   logic [WIDTH-1:0]   rx_sr_q, rx_sr_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [BIT_W-1:0]   cap_cnt_q, cap_cnt_d;
   logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
   logic               rx_full_q, rx_full_d;

   logic               tx_ready_q, tx_ready_d;
   logic [WIDTH-1:0]   rx_data_q, rx_data_d;
   logic               rx_valid_q, rx_valid_d;
   logic               busy_q, busy_d;
   logic               cs_out_q, cs_out_d;
   logic               sdo_q, sdo_d;

   logic               accept_c;
   logic               strobe_c;
   logic               strobe_dly_c;
   logic               bit_end_c;
   logic               last_bit_c;
   logic               done_c;
   logic               leave_c;
   logic [WIDTH-1:0]   rx_shift_c;

   // Handshake and bit-timing decodes
   assign accept_c   = (state_q == S_IDLE) && tx_valid && tx_ready_q;
   assign strobe_c   = (state_q == S_SHIFT) && (cyc_cnt_q == CYC_W'(0));
   assign bit_end_c  = (state_q == S_SHIFT) && (cyc_cnt_q == CYC_W'(BIT_CYCLES - 1));
   assign last_bit_c = (bit_cnt_q == BIT_W'(WIDTH - 1));
   assign done_c     = strobe_dly_c && (cap_cnt_q == BIT_W'(WIDTH - 1));
   assign rx_shift_c = WIDTH'({rx_sr_q, sdi});

   // Sample strobe delayed to line up with the peripheral echo
   if (LATENCY == 0) begin : g_no_dly
      assign strobe_dly_c = strobe_c;
   end else begin : g_dly
      logic [LATENCY-1:0] dly_q;
      always_ff @(posedge clk) begin
         if (reset) begin
            dly_q <= '0;
         end else begin
            dly_q <= (LATENCY)'({dly_q, strobe_c});
         end
      end
      assign strobe_dly_c = dly_q[LATENCY-1];
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         bit_cnt_q  <= '0;
         cap_cnt_q  <= '0;
         cyc_cnt_q  <= '0;
         rx_full_q  <= 1'b0;
         tx_ready_q <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cs_out_q   <= 1'b0;
         sdo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         bit_cnt_q  <= bit_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
         cyc_cnt_q  <= cyc_cnt_d;
         rx_full_q  <= rx_full_d;
         tx_ready_q <= tx_ready_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         cs_out_q   <= cs_out_d;
         sdo_q      <= sdo_d;
      end
   end

   // Next-state logic; a transfer ends only once the shift window is over
   // and every echoed bit has been captured
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept_c) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (bit_end_c && last_bit_c) begin
               state_d = (rx_full_q || done_c) ? S_IDLE : S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (done_c) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values and registered-output next values
   always_comb begin
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      bit_cnt_d = bit_cnt_q;
      cap_cnt_d = cap_cnt_q;
      cyc_cnt_d = cyc_cnt_q;
      rx_full_d = rx_full_q;
      rx_data_d = rx_data_q;
      leave_c   = (state_q != S_IDLE) && (state_d == S_IDLE);

      if (accept_c) begin
         tx_sr_d   = tx_data;
         bit_cnt_d = '0;
         cap_cnt_d = '0;
         cyc_cnt_d = '0;
         rx_full_d = 1'b0;
      end else if (state_q == S_SHIFT) begin
         if (bit_end_c) begin
            cyc_cnt_d = '0;
            if (!last_bit_c) begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               tx_sr_d   = WIDTH'({tx_sr_q, 1'b0});
            end
         end else begin
            cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
         end
      end

      // Echo capture: first bit ends up at the MSB
      if (strobe_dly_c) begin
         rx_sr_d   = rx_shift_c;
         cap_cnt_d = done_c ? '0 : cap_cnt_q + BIT_W'(1);
      end
      if (done_c) rx_full_d = 1'b1;

      if (leave_c) rx_data_d = done_c ? rx_shift_c : rx_sr_q;

      rx_valid_d = leave_c;
      tx_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
      cs_out_d   = (state_d == S_SHIFT);
      sdo_d      = (state_d == S_SHIFT) ? tx_sr_d[WIDTH-1] : 1'b0;
   end

   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign cs_out   = cs_out_q;
   assign sdo      = sdo_q;

endmodule

// File: tb/tb_zero2asic_host.sv
// Bench for zero2asic_host: three instances (loopback LAT1/BC1, loopback
// LAT1/BC3, zero-latency with optional sdi tie-high) against a word-level model.
module tb_zero2asic_host;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data  [3];
   logic       tx_valid [3];
   logic       tx_ready [3];
   logic [7:0] rx_data  [3];
   logic       rx_valid [3];
   logic       busy     [3];
   logic       cs_out   [3];
   logic       sdo      [3];
   logic       sdi_r    [2];
   logic       sdi_c;
   logic       tie1 = 1'b0;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   // Peripheral models: registered echo for A/B, combinational for C
   always @(posedge clk) begin
      sdi_r[0] <= sdo[0];
      sdi_r[1] <= sdo[1];
   end
   assign sdi_c = tie1 ? 1'b1 : sdo[2];

   zero2asic_host #(.WIDTH(8), .BIT_CYCLES(1), .LATENCY(1)) u_a (
      .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
      .busy(busy[0]), .cs_out(cs_out[0]), .sdo(sdo[0]), .sdi(sdi_r[0]));

   zero2asic_host #(.WIDTH(8), .BIT_CYCLES(3), .LATENCY(1)) u_b (
      .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
      .busy(busy[1]), .cs_out(cs_out[1]), .sdo(sdo[1]), .sdi(sdi_r[1]));

   zero2asic_host #(.WIDTH(8), .BIT_CYCLES(1), .LATENCY(0)) u_c (
      .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
      .busy(busy[2]), .cs_out(cs_out[2]), .sdo(sdo[2]), .sdi(sdi_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transfer on instance k, checked cycle by cycle against the pin-level model:
   // cs high for 8*bc cycles, bit (n-1)/bc of the word MSB-first on sdo, rx word at the end.
   task automatic run_xfer(input int k, input logic [7:0] word, input int bc, input int lat,
                           input logic [7:0] exp_rx, input bit inject, input string tag);
      int         n;
      int         rx_at;
      bit         seen;
      logic [7:0] got;
      logic       exp_cs;
      logic       exp_sdo;
      n = 1; seen = 0; rx_at = 0; got = '0;
      chk({tag, "_ready"}, 32'(tx_ready[k]), 32'd1);
      tx_valid[k] = 1'b1;
      tx_data[k]  = word;
      @(negedge clk);
      tx_valid[k] = 1'b0;
      tx_data[k]  = 8'($urandom);
      while (!seen && n <= 200) begin
         exp_cs  = (n <= 8 * bc);
         exp_sdo = exp_cs ? word[7 - (n - 1) / bc] : 1'b0;
         chk($sformatf("%s_cs_c%0d", tag, n), 32'(cs_out[k]), 32'(exp_cs));
         chk($sformatf("%s_sdo_c%0d", tag, n), 32'(sdo[k]), 32'(exp_sdo));
         if (inject && n == 3) begin
            chk({tag, "_ready_busy"}, 32'(tx_ready[k]), 32'd0);
            tx_valid[k] = 1'b1;
            tx_data[k]  = 8'h12;
         end
         if (inject && n == 4) tx_valid[k] = 1'b0;
         if (rx_valid[k]) begin
            seen  = 1;
            rx_at = n;
            got   = rx_data[k];
            chk({tag, "_busy_done"}, 32'(busy[k]), 32'd0);
         end else begin
            chk($sformatf("%s_busy_c%0d", tag, n), 32'(busy[k]), 32'd1);
            @(negedge clk);
            n++;
         end
      end
      chk({tag, "_rx_seen"}, 32'(seen), 32'd1);
      chk({tag, "_rx_data"}, 32'(got), 32'(exp_rx));
      if (bc == 1) chk({tag, "_rx_cycle"}, 32'(rx_at), 32'(8 + lat + 1));
      else chk({tag, "_rx_after_cs"}, 32'(rx_at > 8 * bc), 32'd1);
      @(negedge clk);
      chk({tag, "_rx_pulse"}, 32'(rx_valid[k]), 32'd0);
      chk({tag, "_rx_hold"}, 32'(rx_data[k]), 32'(exp_rx));
      if (inject) begin
         for (int i = 0; i < 12; i++) begin
            chk({tag, "_no_extra_cs"}, 32'(cs_out[k]), 32'd0);
            chk({tag, "_no_extra_rx"}, 32'(rx_valid[k]), 32'd0);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] w;
      int         gap;
      int         pulses;
      int         n;
      logic [7:0] rx_seq [2];
      bit         prev_cs;
      bit         in_gap;

      for (int k = 0; k < 3; k++) begin
         tx_data[k]  = '0;
         tx_valid[k] = 1'b0;
      end

      // Reset values
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(tx_ready[k]), 32'd0);
         chk("rst_cs", 32'(cs_out[k]), 32'd0);
         chk("rst_sdo", 32'(sdo[k]), 32'd0);
         chk("rst_busy", 32'(busy[k]), 32'd0);
         chk("rst_rxv", 32'(rx_valid[k]), 32'd0);
         chk("rst_rxd", 32'(rx_data[k]), 32'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("post_rst_ready", 32'(tx_ready[k]), 32'd1);

      // Directed transfers
      run_xfer(0, 8'hA5, 1, 1, 8'hA5, 1'b0, "a5");
      run_xfer(1, 8'h3C, 3, 1, 8'h3C, 1'b0, "bc3");
      tie1 = 1'b1;
      run_xfer(2, 8'h00, 1, 0, 8'hFF, 1'b0, "tie1");
      tie1 = 1'b0;

      // Back-to-back on the zero-latency instance
      tx_valid[2] = 1'b1;
      tx_data[2]  = 8'h81;
      @(negedge clk);
      tx_data[2] = 8'h7E;
      pulses = 0; gap = 0; prev_cs = 1'b1; in_gap = 0; n = 0;
      rx_seq[0] = '0; rx_seq[1] = '0;
      while (pulses < 2 && n < 60) begin
         chk("b2b_ready_gap", 32'(tx_ready[2]), 32'(!cs_out[2]));
         if (!cs_out[2] && pulses == 0) gap++;
         if (rx_valid[2]) begin
            rx_seq[pulses] = rx_data[2];
            pulses++;
            if (pulses == 2) tx_valid[2] = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      tx_valid[2] = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd2);
      chk("b2b_rx0", 32'(rx_seq[0]), 32'h81);
      chk("b2b_rx1", 32'(rx_seq[1]), 32'h7E);
      chk("b2b_cs_gap", 32'(gap), 32'd1);
      chk("b2b_idle_cs", 32'(cs_out[2]), 32'd0);

      // Reset during bit 4 of an 0xFF transfer
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'hFF;
      @(negedge clk);
      tx_valid[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_cs_before", 32'(cs_out[0]), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_cs", 32'(cs_out[0]), 32'd0);
      chk("rst_mid_busy", 32'(busy[0]), 32'd0);
      chk("rst_mid_sdo", 32'(sdo[0]), 32'd0);
      chk("rst_mid_rxv", 32'(rx_valid[0]), 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("rst_mid_no_rx", 32'(rx_valid[0]), 32'd0);
         chk("rst_mid_no_cs", 32'(cs_out[0]), 32'd0);
      end
      run_xfer(0, 8'h55, 1, 1, 8'h55, 1'b0, "after_rst");

      // tx_valid pulse while busy must be ignored
      run_xfer(0, 8'hC3, 1, 1, 8'hC3, 1'b1, "busy_ign");

      // Randomized words on every instance against the loopback model
      for (int r = 0; r < 4; r++) begin
         w = 8'($urandom);
         run_xfer(0, w, 1, 1, w, 1'b0, $sformatf("rnd_a%0d", r));
         w = 8'($urandom);
         run_xfer(1, w, 3, 1, w, 1'b0, $sformatf("rnd_b%0d", r));
         w = 8'($urandom);
         run_xfer(2, w, 1, 0, w, 1'b0, $sformatf("rnd_c%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
